gf2_poly_div29: RTL and testbench

// - Bit-serial GF(2)[x] long divider: the inverse of the 29x29 Karatsuba carry-less multiplier.
// - Splits a 57-bit product-width polynomial a into quotient q and remainder r by a 29-bit divisor b.
// - Result satisfies a = q*b ^ r, with deg r < deg b.
// - Sits after ks29-style multipliers: field reduction, product checking, and decode of encoded words.

---
 rtl/gf2_div_pkg.sv | 20 ++
 rtl/gf2_div_step.sv | 21 ++
 rtl/gf2_poly_div29.sv | 118 +++++++++++
 tb/tb_gf2_poly_div29.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_div_pkg.sv
// Shared widths, FSM state type and a polynomial-degree helper for the
// bit-serial GF(2)[x] divider.
package gf2_div_pkg;

  localparam int N  = 29;
  localparam int DW = 2*N-1;
  localparam int CW = 7;
  localparam int SW = 5;

  typedef enum logic [2:0] {IDLE, NORM, DIV, FIX, DONE} state_t;

  // Returns the index of the highest set coefficient, or -1 for the zero polynomial
  function automatic int deg(input logic [N-1:0] p);
    for (int i = N-1; i >= 0; i--) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step: shift the next dividend bit into the partial
// remainder and subtract (XOR) the normalised divisor when the top bit is set.
module gf2_div_step
  import gf2_div_pkg::*;
(
  input  logic [N-2:0] r,
  input  logic [N-1:0] d,
  input  logic         bitin,
  output logic [N-1:0] rnext,
  output logic         qbit
);

  logic [N-1:0] shifted;

  always_comb begin
    shifted = {r, bitin};
    qbit    = shifted[N-1];
    rnext   = qbit ? (shifted ^ d) : shifted;
  end

endmodule

// File: rtl/gf2_poly_div29.sv
// Bit-serial GF(2)[x] long divider: a = q*b ^ r for a 57-bit dividend and a
// 29-bit divisor, with a valid/ready handshake on both sides.
module gf2_poly_div29
  import gf2_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [N-1:0]  divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [N-2:0]  remainder,
  output logic          div_by_zero
);

  state_t        state;
  logic [DW-1:0] aReg;
  logic [DW-1:0] qReg;
  logic [N-1:0]  rReg;
  logic [N-1:0]  dReg;
  logic [SW-1:0] shift;
  logic [CW-1:0] cnt;
  logic [N-1:0]  stepR;
  logic          stepQ;

  assign in_ready = (state == IDLE) && !rst;

  gf2_div_step u_step (
    .r     (rReg[N-2:0]),
    .d     (dReg),
    .bitin (aReg[DW-1]),
    .rnext (stepR),
    .qbit  (stepQ)
  );

  // The divisor is first shifted up until its top bit is set (shift counts how
  // far). Division then runs shift extra cycles on zero fill, which leaves the
  // remainder scaled by x^shift; FIX undoes that scaling before results publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      aReg        <= '0;
      qReg        <= '0;
      rReg        <= '0;
      dReg        <= '0;
      shift       <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              quotient    <= '0;
              remainder   <= dividend[N-2:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              aReg  <= dividend;
              dReg  <= divisor;
              rReg  <= '0;
              qReg  <= '0;
              shift <= '0;
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (dReg[N-1]) begin
            cnt   <= CW'(DW-1) + CW'(shift);
            state <= DIV;
          end else begin
            dReg  <= dReg << 1;
            shift <= shift + SW'(1);
          end
        end
        DIV: begin
          rReg <= stepR;
          qReg <= {qReg[DW-2:0], stepQ};
          aReg <= aReg << 1;
          if (cnt == '0) begin
            cnt   <= CW'(shift);
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (cnt == '0) begin
            quotient    <= qReg;
            remainder   <= rReg[N-2:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            rReg <= rReg >> 1;
            cnt  <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_div29.sv
// Self-checking bench for gf2_poly_div29: directed vector table, backpressure
// and mid-operation reset sequences, and randomized division against a model.
module tb_gf2_poly_div29;
  import gf2_div_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [N-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [N-2:0]  remainder;
  logic          div_by_zero;

  int vecCount  = 0;
  int missCount = 0;

  // waitEdges counts clock edges after the accept edge until out_valid is seen
  typedef struct {
    logic [DW-1:0] a;
    logic [N-1:0]  b;
    logic [DW-1:0] q;
    logic [N-2:0]  r;
    logic          dbz;
    int            waitEdges;
  } vec_t;

  vec_t vecs[4];

  gf2_poly_div29 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Textbook long division by degree, cancelling the leading term each step
  function automatic void divModel(input logic [DW-1:0] a, input logic [N-1:0] b,
                                   output logic [DW-1:0] q, output logic [N-2:0] r);
    logic [63:0] rem;
    int db;
    q  = '0;
    db = deg(b);
    if (db < 0) begin
      r = a[N-2:0];
      return;
    end
    rem = 64'(a);
    for (int i = DW-1; i >= db; i--) begin
      if (rem[i]) begin
        q[i-db] = 1'b1;
        rem     = rem ^ (64'(b) << (i-db));
      end
    end
    r = rem[N-2:0];
  endfunction

  function automatic logic [DW-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [DW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) p = p ^ (DW'(y) << i);
    end
    return p;
  endfunction

  function automatic int expectedEdges(input logic [N-1:0] b);
    if (b == '0) return 0;
    return DW + 3*(N-1-deg(b)) + 2;
  endfunction

  function automatic logic [DW-1:0] rand57();
    logic [63:0] w;
    w = {$urandom, $urandom};
    return w[DW-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offers one operation, scrambles the inputs after accept, then waits for out_valid
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [N-1:0] b,
                               input logic earlyReady, output int edges);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = rand57();
    divisor   = N'($urandom);
    out_ready = earlyReady;
    edges = 0;
    while (!out_valid && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL timeout: out_valid still 0 after %0d edges, required 1", edges);
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid_after_ready", 64'(out_valid), 64'd0);
    checkOutput("in_ready_after_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic runVector(input string tag, input logic [DW-1:0] a, input logic [N-1:0] b,
                           input logic [DW-1:0] expQ, input logic [N-2:0] expR,
                           input logic expDbz, input int expEdges, input logic earlyReady);
    int edges;
    applyStimulus(a, b, earlyReady, edges);
    checkOutput({tag, "_quotient"}, 64'(quotient), 64'(expQ));
    checkOutput({tag, "_remainder"}, 64'(remainder), 64'(expR));
    checkOutput({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(expDbz));
    checkOutput({tag, "_latency"}, 64'(edges), 64'(expEdges));
    releaseResult();
  endtask

  initial begin
    logic [DW-1:0] a, mq, heldQ;
    logic [N-1:0]  b;
    logic [N-2:0]  mr, heldR;
    int            edges, db;

    vecs[0] = '{a: 57'h5, b: 29'h3, q: 57'h3, r: 28'h0, dbz: 1'b0, waitEdges: 140};
    vecs[1] = '{a: 57'h1FF_FFFF_FFFF_FFFF, b: 29'h1000_0000, q: 57'h1FFF_FFFF,
                r: 28'hFFF_FFFF, dbz: 1'b0, waitEdges: 59};
    vecs[2] = '{a: 57'h0AB_CDEF_0123_4567, b: 29'h1, q: 57'h0AB_CDEF_0123_4567,
                r: 28'h0, dbz: 1'b0, waitEdges: 143};
    vecs[3] = '{a: 57'h123_4567_89AB, b: 29'h0, q: 57'h0, r: 28'h567_89AB,
                dbz: 1'b1, waitEdges: 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_quotient", 64'(quotient), 64'd0);
    checkOutput("reset_remainder", 64'(remainder), 64'd0);
    checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 4; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                vecs[i].dbz, vecs[i].waitEdges, 1'b0);
    end

    $display("[TB] backpressure hold in DONE");
    applyStimulus(vecs[0].a, vecs[0].b, 1'b0, edges);
    heldQ = quotient;
    heldR = remainder;
    checkOutput("bp_quotient", 64'(quotient), 64'(vecs[0].q));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_quotient_stable", 64'(quotient), 64'(heldQ));
      checkOutput("bp_remainder_stable", 64'(remainder), 64'(heldR));
    end
    releaseResult();
    checkOutput("bp_quotient_kept", 64'(quotient), 64'(heldQ));

    $display("[TB] reset during division");
    dividend = vecs[0].a;
    divisor  = vecs[0].b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("mid_op_busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid_rst_quotient", 64'(quotient), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    runVector("after_rst", vecs[0].a, vecs[0].b, vecs[0].q, vecs[0].r, 1'b0,
              vecs[0].waitEdges, 1'b0);

    $display("[TB] random divisors of mixed degree");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = '0;
      end else begin
        db = $urandom_range(0, N-1);
        b  = N'($urandom) & ((N'(1) << db) - N'(1));
        b[db] = 1'b1;
      end
      a = rand57() >> $urandom_range(0, DW-1);
      divModel(a, b, mq, mr);
      runVector("mixed", a, b, mq, mr, (b == '0), expectedEdges(b), 1'($urandom_range(0, 1)));
    end

    $display("[TB] random degree-28 divisors");
    for (int i = 0; i < 1000; i++) begin
      b = {1'b1, 28'($urandom)};
      a = rand57();
      divModel(a, b, mq, mr);
      applyStimulus(a, b, 1'($urandom_range(0, 1)), edges);
      checkOutput("d28_identity", 64'(clmul(quotient[N-1:0], b) ^ DW'(remainder)), 64'(a));
      checkOutput("d28_q_high_zero", 64'(quotient[DW-1:N]), 64'd0);
      checkOutput("d28_quotient", 64'(quotient), 64'(mq));
      checkOutput("d28_remainder", 64'(remainder), 64'(mr));
      checkOutput("d28_latency", 64'(edges), 64'd59);
      releaseResult();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
